// File: rtl/ovr_i_pkg.sv
// Shared types and default parameter values for the over-current guard.
package ovr_i_pkg;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        BLANK = 2'd1,
        SENSE = 2'd2
    } period_state_t;

    localparam int BLANK_CYC_DEF    = 128;
    localparam int TRIP_PERIODS_DEF = 16;
    localparam int FLT_CNT_W_DEF    = 8;

endpackage

// File: rtl/ovr_i_guard_synch2.sv
// Two-flop synchroniser for an asynchronous flag; output lags the input by 2 clocks.
module synch2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/ovr_i_guard.sv
// Over-current guard: blanks bridge flags after each PWM period start, counts
// consecutive over-current periods and latches a shutdown with a saturating trip count.
module ovr_i_guard
    import ovr_i_pkg::*;
#(
    parameter int BLANK_CYC    = BLANK_CYC_DEF,
    parameter int TRIP_PERIODS = TRIP_PERIODS_DEF,
    parameter int FLT_CNT_W    = FLT_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pwm_synch,
    input  logic                 OVR_I_lft,
    input  logic                 OVR_I_rght,
    input  logic                 clr_fault,
    output logic                 shtdwn,
    output logic                 trip_lft,
    output logic                 trip_rght,
    output logic [FLT_CNT_W-1:0] flt_cnt
);

    localparam int BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int CON_W = $clog2(TRIP_PERIODS + 1);
    localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLANK_CYC - 1);
    localparam logic [CON_W-1:0] TRIP_N   = CON_W'(TRIP_PERIODS);

    function automatic logic [CON_W-1:0] sat_inc_consec(input logic [CON_W-1:0] v);
        return (v >= TRIP_N) ? TRIP_N : v + 1'b1;
    endfunction

    function automatic logic [FLT_CNT_W-1:0] sat_inc_flt(input logic [FLT_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic w_ovr_l_s;
    logic w_ovr_r_s;

    synch2 u_sync_l (.clk(clk), .rst(rst), .d(OVR_I_lft),  .q(w_ovr_l_s));
    synch2 u_sync_r (.clk(clk), .rst(rst), .d(OVR_I_rght), .q(w_ovr_r_s));

    period_state_t        r_state;
    logic [BLK_W-1:0]     r_blank_cnt;
    logic                 r_hit_l;
    logic                 r_hit_r;
    logic [CON_W-1:0]     r_consec;
    logic                 r_shtdwn;
    logic                 r_trip_l;
    logic                 r_trip_r;
    logic [FLT_CNT_W-1:0] r_flt_cnt;

    logic             w_sense;
    logic             w_hit_l;
    logic             w_hit_r;
    logic             w_eval;
    logic [CON_W-1:0] w_consec_nxt;
    logic             w_trip;

    // A hit sampled on the period-end clock still belongs to the ending period.
    assign w_sense      = (r_state == SENSE);
    assign w_hit_l      = r_hit_l | (w_sense & w_ovr_l_s);
    assign w_hit_r      = r_hit_r | (w_sense & w_ovr_r_s);
    assign w_eval       = pwm_synch & (r_state != WAIT);
    assign w_consec_nxt = (w_hit_l | w_hit_r) ? sat_inc_consec(r_consec) : '0;
    assign w_trip       = w_eval & ~r_shtdwn & (w_consec_nxt == TRIP_N);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= WAIT;
            r_blank_cnt <= '0;
            r_hit_l     <= 1'b0;
            r_hit_r     <= 1'b0;
        end else begin
            case (r_state)
                WAIT: begin
                    if (pwm_synch) begin
                        r_state     <= BLANK;
                        r_blank_cnt <= BLK_LOAD;
                    end
                end
                BLANK, SENSE: begin
                    if (pwm_synch) begin
                        r_state     <= BLANK;
                        r_blank_cnt <= BLK_LOAD;
                        r_hit_l     <= 1'b0;
                        r_hit_r     <= 1'b0;
                    end else if (r_state == BLANK) begin
                        if (r_blank_cnt == '0) begin
                            r_state <= SENSE;
                        end else begin
                            r_blank_cnt <= r_blank_cnt - 1'b1;
                        end
                    end else begin
                        r_hit_l <= w_hit_l;
                        r_hit_r <= w_hit_r;
                    end
                end
                default: begin
                    r_state <= WAIT;
                end
            endcase
        end
    end

    // While shut down, evaluations are ignored and the consecutive count stays at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_consec  <= '0;
            r_shtdwn  <= 1'b0;
            r_trip_l  <= 1'b0;
            r_trip_r  <= 1'b0;
            r_flt_cnt <= '0;
        end else if (r_shtdwn) begin
            r_consec <= '0;
            if (clr_fault) begin
                r_shtdwn <= 1'b0;
            end
        end else if (w_trip) begin
            r_shtdwn  <= 1'b1;
            r_trip_l  <= w_hit_l;
            r_trip_r  <= w_hit_r;
            r_flt_cnt <= sat_inc_flt(r_flt_cnt);
            r_consec  <= '0;
        end else if (w_eval) begin
            r_consec <= w_consec_nxt;
        end
    end

    assign shtdwn    = r_shtdwn;
    assign trip_lft  = r_trip_l;
    assign trip_rght = r_trip_r;
    assign flt_cnt   = r_flt_cnt;

endmodule

// File: tb/tb_ovr_i_guard.sv
// Directed bench for ovr_i_guard with a short blanking window so full trip sequences stay fast.
module tb_ovr_i_guard;

    localparam int BLANK_CYC    = 8;
    localparam int TRIP_PERIODS = 16;
    localparam int FLT_CNT_W    = 8;
    localparam int PER          = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 pwm_synch;
    logic                 OVR_I_lft;
    logic                 OVR_I_rght;
    logic                 clr_fault;
    logic                 shtdwn;
    logic                 trip_lft;
    logic                 trip_rght;
    logic [FLT_CNT_W-1:0] flt_cnt;

    int n_vec = 0;
    int n_bad = 0;
    int exp_flt;

    ovr_i_guard #(
        .BLANK_CYC   (BLANK_CYC),
        .TRIP_PERIODS(TRIP_PERIODS),
        .FLT_CNT_W   (FLT_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_synch (pwm_synch),
        .OVR_I_lft (OVR_I_lft),
        .OVR_I_rght(OVR_I_rght),
        .clr_fault (clr_fault),
        .shtdwn    (shtdwn),
        .trip_lft  (trip_lft),
        .trip_rght (trip_rght),
        .flt_cnt   (flt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One PWM period: strobe on cycle 0, left flag on [ls,le), right flag on [rs,re),
    // optional one-cycle reset on cycle rst_c.
    task automatic run_period(input int len, input int ls, input int le,
                              input int rs, input int re, input int rst_c);
        for (int c = 0; c < len; c++) begin
            pwm_synch  = (c == 0);
            OVR_I_lft  = (c >= ls) && (c < le);
            OVR_I_rght = (c >= rs) && (c < re);
            rst        = (c == rst_c);
            step();
        end
        pwm_synch  = 1'b0;
        OVR_I_lft  = 1'b0;
        OVR_I_rght = 1'b0;
        rst        = 1'b0;
    endtask

    task automatic strobe();
        pwm_synch = 1'b1;
        step();
        pwm_synch = 1'b0;
    endtask

    task automatic clear();
        clr_fault = 1'b1;
        step();
        clr_fault = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        pwm_synch  = 1'b0;
        OVR_I_lft  = 1'b0;
        OVR_I_rght = 1'b0;
        clr_fault  = 1'b0;
        repeat (3) step();
        chk("rst_shtdwn", shtdwn, 0);
        chk("rst_trip_l", trip_lft, 0);
        chk("rst_trip_r", trip_rght, 0);
        chk("rst_flt", flt_cnt, 0);
        rst = 1'b0;

        // Left pulses entirely inside the blanking window
        for (int p = 0; p < 30; p++) run_period(PER, 1, 6, 0, 0, -1);
        chk("blank_shtdwn", shtdwn, 0);
        chk("blank_flt", flt_cnt, 0);

        // 15 hit periods, one clean, 15 hit: counter restarts, no trip
        for (int p = 0; p < 15; p++) run_period(PER, 0, 0, 12, 20, -1);
        run_period(PER, 0, 0, 0, 0, -1);
        for (int p = 0; p < 15; p++) run_period(PER, 0, 0, 12, 20, -1);
        strobe();
        chk("noncons_shtdwn", shtdwn, 0);
        chk("noncons_flt", flt_cnt, 0);

        // Right-side trip on the 16th consecutive hit period
        for (int p = 0; p < 16; p++) run_period(PER, 0, 0, 12, 20, -1);
        chk("trip_r_pre", shtdwn, 0);
        strobe();
        chk("trip_r_shtdwn", shtdwn, 1);
        chk("trip_r_l", trip_lft, 0);
        chk("trip_r_r", trip_rght, 1);
        chk("trip_r_flt", flt_cnt, 1);

        clear();
        chk("clr_shtdwn", shtdwn, 0);
        chk("clr_hold_r", trip_rght, 1);

        // Both sides
        for (int p = 0; p < 16; p++) run_period(PER, 12, 20, 12, 20, -1);
        chk("trip_lr_pre", shtdwn, 0);
        strobe();
        chk("trip_lr_shtdwn", shtdwn, 1);
        chk("trip_lr_l", trip_lft, 1);
        chk("trip_lr_r", trip_rght, 1);
        chk("trip_lr_flt", flt_cnt, 2);

        // Shutdown holds; no further trips counted
        for (int p = 0; p < 20; p++) run_period(PER, 12, 20, 12, 20, -1);
        strobe();
        chk("hold_shtdwn", shtdwn, 1);
        chk("hold_flt", flt_cnt, 2);
        run_period(PER, 0, 0, 0, 0, -1);
        clear();
        chk("clr2_shtdwn", shtdwn, 0);

        // clr_fault while not shut down must not disturb the consecutive count
        for (int p = 0; p < 8; p++) run_period(PER, 0, 0, 12, 20, -1);
        clear();
        chk("clr_noeff_shtdwn", shtdwn, 0);
        for (int p = 0; p < 8; p++) run_period(PER, 0, 0, 12, 20, -1);
        chk("clr_noeff_pre", shtdwn, 0);
        strobe();
        chk("clr_noeff_trip", shtdwn, 1);
        chk("clr_noeff_flt", flt_cnt, 3);
        chk("clr_noeff_l", trip_lft, 0);
        chk("clr_noeff_r", trip_rght, 1);

        // Reset in the sensing part of period 10
        for (int p = 0; p < 9; p++) run_period(PER, 0, 0, 12, 20, -1);
        run_period(PER, 0, 0, 12, 20, 20);
        chk("midrst_shtdwn", shtdwn, 0);
        chk("midrst_trip_l", trip_lft, 0);
        chk("midrst_trip_r", trip_rght, 0);
        chk("midrst_flt", flt_cnt, 0);
        for (int p = 0; p < 16; p++) run_period(PER, 0, 0, 12, 20, -1);
        chk("midrst_15_no_trip", shtdwn, 0);
        strobe();
        chk("midrst_16_trip", shtdwn, 1);
        chk("midrst_flt1", flt_cnt, 1);

        // Saturation of the trip counter
        exp_flt = 1;
        for (int t = 0; t < 260; t++) begin
            clear();
            for (int p = 0; p < 16; p++) run_period(BLANK_CYC + 4, 0, BLANK_CYC + 4, 0, 0, -1);
            strobe();
            exp_flt = (exp_flt >= 255) ? 255 : exp_flt + 1;
            chk("sat_shtdwn", shtdwn, 1);
            chk("sat_flt", flt_cnt, exp_flt);
        end
        chk("sat_final", flt_cnt, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
